pipe_skid_reg: RTL
==================

# pipe_skid_reg

Two-entry elastic pipeline register (skid buffer) with valid/ready handshakes on both sides, carrying an N-bit payload between pipeline stages of the MIPS core. It sits directly upstream of the stage operand-select multiplexers and feeds their data inputs. It gives full throughput (one transfer per cycle) with a registered `in_ready`, so backpressure never forms a combinational path through the stage. A synchronous `flush` discards in-flight entries on branch or exception redirect.

## Interface
- `N`, default 32: payload width in bits.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous discard of all held entries.
- `in_valid` in 1: upstream offers `in_data`.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in N: upstream payload.
- `out_valid` out 1: `out_data` holds a valid entry; registered.
- `out_ready` in 1: downstream consumes this cycle.
- `out_data` out N: head payload; registered.
- `occupancy` out 2: number of held entries, 0..2.

## Operation
- Definitions:
  - accept = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- Storage: `main` register drives `out_data`; the `skid` register holds the overflow entry.
- States (enum): `EMPTY` (occupancy 0), `ONE` (occupancy 1), `TWO` (occupancy 2).
- Transitions, when `flush` = 0:
  - `EMPTY`: accept -> `ONE`, `main` <= `in_data`. Otherwise stay.
  - `ONE`, accept and pop: stay in `ONE`, `main` <= `in_data`.
  - `ONE`, accept and no pop: -> `TWO`, `skid` <= `in_data`.
  - `ONE`, pop and no accept: -> `EMPTY`.
  - `ONE`, neither: hold.
  - `TWO`: no accept is possible. Pop -> `ONE`, `main` <= `skid`. Otherwise hold.
- Outputs are decoded from the state:
  - `in_ready` = (state != `TWO`).
  - `out_valid` = (state != `EMPTY`).
  - `occupancy` = state encoding.
- `flush` = 1:
  - Next state is `EMPTY` regardless of other inputs.
  - An accept in the same cycle is dropped.
  - A pop in the same cycle counts as completed for downstream.
  - `main` and `skid` keep their values; `out_data` keeps its last value while `out_valid` = 0.
- Ordering: entries leave in exactly the order they were accepted. No duplication, no loss except on `flush`.
- Stability: while `out_valid & !out_ready`, `out_data` must not change.
- The payload width is passed through unchanged. No arithmetic is performed on the payload.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = `EMPTY`.
  - `out_valid` = 0, `in_ready` = 1, `occupancy` = 0.
  - `out_data` = 0, `skid` = 0.
- Reset asserted mid-transfer discards all entries immediately. There is no recovery of in-flight data.
- Latency: data accepted at edge k is on `out_data` with `out_valid` = 1 after edge k, i.e. visible in cycle k+1.
- Throughput: with `out_ready` held at 1, one transfer per cycle; occupancy stays at 1.
- `in_ready` drops one cycle after the second entry is captured. The skid entry absorbs the single in-flight beat.
- `in_ready` returns to 1 the cycle after the first pop from `TWO`.
- First accept after reset is possible on the first rising edge with `rst_n` high.

## Structure
- Shared package `pipe_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY=2'd0, ONE=2'd1, TWO=2'd2} skid_state_t`.
  - Constant `SKID_DEPTH = 2`.
- One sub-module: `nmux21 #(.N(N))` selects the `main` next value, with `a` = `in_data`, `b` = `skid`, `s` = (state == `TWO`).
- Registers are held in a single `always_ff` block with asynchronous reset. Next-state logic is held in an `always_comb` block.

## Test plan
- Reset/basic pass: release `rst_n`, hold `out_ready` = 1, drive `in_data` = 32'hAAAAAAAA with `in_valid` for 1 cycle. Required: `out_valid` = 1 with `out_data` = 32'hAAAAAAAA in the next cycle, then `occupancy` returns to 0.
- Streaming: drive 0x1..0x8 back-to-back with `out_ready` = 1. Required: 0x1..0x8 are output on 8 consecutive cycles and `in_ready` stays 1 throughout.
- Backpressure: set `out_ready` = 0 and send 0x11, then 0x22. Required:
  - `occupancy` = 2 and `in_ready` = 0.
  - `out_data` holds 0x11 stable.
  - After `out_ready` = 1, 0x11 then 0x22 are output in order and `in_ready` returns to 1.
- Flush: with `occupancy` = 2 (0x33, 0x44), pulse `flush` while `in_valid` carries 0x55. Required: next cycle `out_valid` = 0, `occupancy` = 0, and none of 0x33, 0x44 or 0x55 is ever output.
- Async reset mid-operation: with `occupancy` = 2, pull `rst_n` low mid-cycle. Required: `out_valid` = 0, `in_ready` = 1 and `out_data` = 0 immediately, before the next clock edge.
- Random: drive `in_valid` and `out_ready` randomly for 1000 cycles. A scoreboard checks order and stability, and checks that no accept happens while `in_ready` = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline register slice.
//   skid_state_t : occupancy-encoded state of the two-entry skid buffer.
//   SKID_DEPTH   : number of entries the buffer can hold.
package pipe_pkg;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/pipe_skid_reg_nmux21.sv
// nmux21: N-bit 2:1 multiplexer.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : selected value
module nmux21 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register (skid buffer).
//
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   flush            : synchronous discard of all held entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occupancy        : number of held entries (0..2); equals the FSM state
//                      encoding, so it also serves as the state debug view
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid and ready are both 1. The producer holds valid and data stable until
// the transfer; ready may change freely. in_ready, out_valid and out_data are
// all decoded from registers, so no combinational path runs from out_ready to
// in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_t  state_q, state_d;
  logic [N-1:0] main_q, skid_q;
  logic [N-1:0] main_nxt;
  logic         main_load, skid_load;
  logic         accept, pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // In TWO the head is refilled from the skid entry; otherwise from upstream.
  nmux21 #(.N(N)) u_main_mux (
    .a (in_data),
    .b (skid_q),
    .s (state_q == TWO),
    .y (main_nxt)
  );

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      // Payload registers keep their contents; only the state is cleared, so
      // out_data stays put while out_valid drops.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_load) main_q <= main_nxt;
      if (skid_load) skid_q <= in_data;
    end
  end

endmodule
